// File: rtl/fifo_rd_if.sv
// Consumer-side valid/ready bus for the dual-clock FIFO read controller.
interface fifo_rd_if #(
  parameter int unsigned data_size = 8
);
  logic                 rd_valid;
  logic [data_size-1:0] rd_data;
  logic                 rd_ready;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the dual-clock FIFO: synchronises the write
// Gray pointer, generates empty, drives the memory read address and hides
// the one-cycle memory latency behind a 2-entry first-word-fall-through
// output stage.
// Optional: define FIFO_RD_LEVEL_EN to add the registered rd_level output.
module fifo_rd_ctrl #(
  parameter int unsigned data_size = 8,
  parameter int unsigned add_size  = 4
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst_n,
  input  logic [add_size:0]    wr_ptr_gray,
  output logic [add_size-1:0]  rd_addr,
  input  logic [data_size-1:0] mem_data,
  output logic [add_size:0]    rd_ptr_gray,
  output logic                 empty,
`ifdef FIFO_RD_LEVEL_EN
  output logic [add_size:0]    rd_level,
`endif
  fifo_rd_if.master            rd_if
);

  localparam int unsigned PW = add_size + 1;

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} buf_state_t;

  buf_state_t           state, state_next;
  logic [PW-1:0]        rbin, rbin_next;
  logic [PW-1:0]        rgray_next;
  logic [PW-1:0]        wq1, wq2;
  logic                 inflight;
  logic                 rd_valid_q, rd_valid_next;
  logic [data_size-1:0] head, head_next;
  logic [data_size-1:0] second, second_next;
  logic                 empty_next;
  logic                 pop_c, fetch_c;
  logic [1:0]           count_c;
  logic [2:0]           occ_c;

  assign rd_addr        = rbin[add_size-1:0];
  assign rd_if.rd_valid = rd_valid_q;
  assign rd_if.rd_data  = head;

  // Fetch decision, pointer advance, empty flag and output-stage transitions.
  always_comb begin
    state_next    = state;
    head_next     = head;
    second_next   = second;
    count_c       = 2'd0;
    pop_c         = rd_valid_q && rd_if.rd_ready;

    case (state)
      S_ONE:   count_c = 2'd1;
      S_TWO:   count_c = 2'd2;
      default: count_c = 2'd0;
    endcase

    // Never let buffered plus in-flight words exceed the two buffer slots.
    occ_c      = 3'(count_c) + 3'(inflight) - 3'(pop_c);
    fetch_c    = !empty && (occ_c < 3'd2);
    rbin_next  = rbin + PW'(fetch_c);
    rgray_next = rbin_next ^ (rbin_next >> 1);
    empty_next = (rgray_next == wq2);

    // A word fetched last edge lands on mem_data now and is pushed in.
    case (state)
      S_EMPTY: begin
        if (inflight) begin
          state_next = S_ONE;
          head_next  = mem_data;
        end
      end
      S_ONE: begin
        if (inflight && pop_c) begin
          head_next = mem_data;
        end else if (inflight) begin
          state_next  = S_TWO;
          second_next = mem_data;
        end else if (pop_c) begin
          state_next = S_EMPTY;
        end
      end
      S_TWO: begin
        if (pop_c) begin
          state_next = S_ONE;
          head_next  = second;
        end
      end
      default: state_next = S_EMPTY;
    endcase

    rd_valid_next = (state_next != S_EMPTY);
  end

  // State, pointers, synchroniser and output-stage registers.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state       <= S_EMPTY;
      rbin        <= '0;
      rd_ptr_gray <= '0;
      wq1         <= '0;
      wq2         <= '0;
      empty       <= 1'b1;
      inflight    <= 1'b0;
      rd_valid_q  <= 1'b0;
      head        <= '0;
      second      <= '0;
    end else begin
      state       <= state_next;
      rbin        <= rbin_next;
      rd_ptr_gray <= rgray_next;
      wq1         <= wr_ptr_gray;
      wq2         <= wq1;
      empty       <= empty_next;
      inflight    <= fetch_c;
      rd_valid_q  <= rd_valid_next;
      head        <= head_next;
      second      <= second_next;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [PW-1:0] wq2_bin_c;

  // Gray-to-binary conversion of the synchronised write pointer.
  always_comb begin
    wq2_bin_c         = '0;
    wq2_bin_c[PW-1]   = wq2[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      wq2_bin_c[i] = wq2_bin_c[i+1] ^ wq2[i];
    end
  end

  // Unread words still in memory, excluding the output stage.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_level <= '0;
    end else begin
      rd_level <= wq2_bin_c - rbin_next;
    end
  end
`endif

endmodule
